// File: rtl/pipe_imem_loader.sv
`timescale 1ns/1ps
// pipe_imem_loader
//   Program loader for the pipelined CPU's instruction memory. Accepts a byte
//   stream (count lo, count hi, 4N little-endian payload bytes, XOR checksum)
//   over a valid/ready handshake. It writes each assembled 32-bit word to
//   consecutive word addresses. The CPU is held in reset until the whole image
//   is written and the checksum matches.
//
// Ports
//   clock, resetn      system clock (rising edge), async active-low reset
//   ld_start           one-cycle pulse that begins a load (ignored while busy)
//   in_valid, in_data  byte source; a transfer occurs on in_valid && in_ready
//   in_ready           loader accepts a byte this cycle
//   im_we/addr/wdata   instruction-memory write port, one pulse per word
//   cpu_resetn         active-low reset to the CPU
//   ld_busy            load in progress
//   ld_done, ld_err    sticky outcome of the last load
module pipe_imem_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  ld_start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic [31:0]           im_wdata,
    output logic                  cpu_resetn,
    output logic                  ld_busy,
    output logic                  ld_done,
    output logic                  ld_err
);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        WRITE,
        CKSUM,
        DONE,
        ERR
    } state_t;

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] WORD_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state;
    logic [7:0]            cnt_lo;
    logic [ADDR_WIDTH:0]   n_words;   // one bit wider than the address so N == DEPTH fits
    logic [ADDR_WIDTH:0]   widx;
    logic [1:0]            bidx;
    logic [23:0]           asm_word;  // lanes 0..2; lane 3 goes straight to im_wdata
    logic [7:0]            ck;

    logic                  xfer;
    logic [15:0]           hdr_count;
    logic [ADDR_WIDTH:0]   widx_next;
    logic                  count_too_big;
    logic                  count_zero;

    always_comb begin
        xfer          = in_valid && in_ready;
        hdr_count     = {in_data, cnt_lo};
        widx_next     = widx + WORD_ONE;
        count_too_big = {16'd0, hdr_count} > DEPTH;
        count_zero    = (hdr_count == '0);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            im_we      <= 1'b0;
            im_addr    <= '0;
            im_wdata   <= '0;
            cpu_resetn <= 1'b0;
            ld_busy    <= 1'b0;
            ld_done    <= 1'b0;
            ld_err     <= 1'b0;
            cnt_lo     <= '0;
            n_words    <= '0;
            widx       <= '0;
            bidx       <= '0;
            asm_word   <= '0;
            ck         <= '0;
        end else begin
            im_we <= 1'b0;
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (ld_start) begin
                        state      <= HDR0;
                        in_ready   <= 1'b1;
                        ld_busy    <= 1'b1;
                        cpu_resetn <= 1'b0;
                        ld_done    <= 1'b0;
                        ld_err     <= 1'b0;
                        widx       <= '0;
                        bidx       <= '0;
                        ck         <= '0;
                    end else if (state == IDLE) begin
                        cpu_resetn <= 1'b1;
                    end
                end
                HDR0: begin
                    if (xfer) begin
                        cnt_lo <= in_data;
                        state  <= HDR1;
                    end
                end
                HDR1: begin
                    if (xfer) begin
                        n_words <= hdr_count[ADDR_WIDTH:0];
                        if (count_too_big) begin
                            state    <= ERR;
                            in_ready <= 1'b0;
                            ld_busy  <= 1'b0;
                            ld_err   <= 1'b1;
                        end else if (count_zero) begin
                            state <= CKSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        ck <= ck ^ in_data;
                        unique case (bidx)
                            2'd0: asm_word[7:0]   <= in_data;
                            2'd1: asm_word[15:8]  <= in_data;
                            2'd2: asm_word[23:16] <= in_data;
                            default: ;
                        endcase
                        if (bidx == 2'd3) begin
                            // Write port is loaded on the edge entering WRITE so
                            // the registered strobe lines up with that state.
                            state    <= WRITE;
                            in_ready <= 1'b0;
                            im_we    <= 1'b1;
                            im_addr  <= widx[ADDR_WIDTH-1:0];
                            im_wdata <= {in_data, asm_word};
                        end else begin
                            bidx <= bidx + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    widx     <= widx_next;
                    bidx     <= '0;
                    in_ready <= 1'b1;
                    state    <= (widx_next == n_words) ? CKSUM : DATA;
                end
                CKSUM: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        ld_busy  <= 1'b0;
                        if (in_data == ck) begin
                            state      <= DONE;
                            ld_done    <= 1'b1;
                            cpu_resetn <= 1'b1;
                        end else begin
                            state  <= ERR;
                            ld_err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_imem_loader.sv
`timescale 1ns/1ps
module tb_pipe_imem_loader;

    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          resetn;
    logic          ld_start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          cpu_resetn;
    logic          ld_busy;
    logic          ld_done;
    logic          ld_err;

    pipe_imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .ld_start   (ld_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .cpu_resetn (cpu_resetn),
        .ld_busy    (ld_busy),
        .ld_done    (ld_done),
        .ld_err     (ld_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct {
        logic [15:0] count;
        bit          fixed;
        logic [7:0]  flip;
        bit          toggle;
        bit          inject;
        bit          exp_done;
    } load_t;

    wr_t         exp_q[$];
    int unsigned n_cmp    = 0;
    int unsigned n_bad    = 0;
    int unsigned n_writes = 0;
    logic [31:0] fixed_w [2];
    load_t       tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clock);
            if (resetn === 1'b1 && im_we === 1'b1) begin
                n_writes++;
                check("ready_low_in_write", {31'd0, in_ready}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write", im_addr, im_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", {26'd0, im_addr}, {26'd0, e.addr});
                    check("write_data", im_wdata, e.data);
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit toggle);
        int unsigned waited = 0;
        bit          got    = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!got && waited < 100) begin
            @(negedge clock);
            if (in_ready === 1'b1) got = 1;
            @(posedge clock);
            #1;
            waited++;
        end
        in_valid = 1'b0;
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL byte_timeout: got no in_ready expected accept of %h", b);
        end
        if (toggle) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_start();
        ld_start = 1'b1;
        @(posedge clock);
        #1;
        ld_start = 1'b0;
    endtask

    task automatic run_load(input load_t t);
        logic [31:0] w;
        logic [7:0]  b;
        logic [7:0]  ck_v = 8'h00;
        int unsigned w0   = n_writes;
        pulse_start();
        check("start_busy", {31'd0, ld_busy}, 32'd1);
        check("start_cpu_held", {31'd0, cpu_resetn}, 32'd0);
        check("start_flags_clear", {30'd0, ld_done, ld_err}, 32'd0);
        check("start_ready", {31'd0, in_ready}, 32'd1);
        send_byte(t.count[7:0], t.toggle);
        send_byte(t.count[15:8], t.toggle);
        if (int'(t.count) > DEPTH) begin
            check("oversize_err", {29'd0, ld_err, ld_busy, cpu_resetn}, 32'd4);
            check("oversize_ready", {31'd0, in_ready}, 32'd0);
            repeat (3) begin
                @(posedge clock);
                #1;
            end
            check("oversize_no_writes", n_writes - w0, 32'd0);
            check("oversize_err_sticky", {30'd0, ld_done, ld_err}, 32'd1);
            return;
        end
        for (int k = 0; k < int'(t.count); k++) begin
            w = t.fixed ? fixed_w[k] : $urandom;
            exp_q.push_back('{addr: AW'(k), data: w});
            for (int j = 0; j < 4; j++) begin
                b = w[8*j +: 8];
                ck_v ^= b;
                if (t.inject && k == 0 && j == 2) ld_start = 1'b1;
                send_byte(b, t.toggle);
                ld_start = 1'b0;
            end
        end
        check("cksum_cpu_held", {30'd0, cpu_resetn, ld_busy}, 32'd1);
        send_byte(ck_v ^ t.flip, t.toggle);
        check("end_done", {31'd0, ld_done}, {31'd0, t.exp_done});
        check("end_err", {31'd0, ld_err}, {31'd0, !t.exp_done});
        check("end_busy", {31'd0, ld_busy}, 32'd0);
        check("end_cpu_resetn", {31'd0, cpu_resetn}, {31'd0, t.exp_done});
        check("end_ready", {31'd0, in_ready}, 32'd0);
        check("end_write_count", n_writes - w0, 32'(t.count));
        check("end_queue_empty", exp_q.size(), 32'd0);
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        check("hold_cpu_resetn", {31'd0, cpu_resetn}, {31'd0, t.exp_done});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        fixed_w[0] = 32'h2008_0013;
        fixed_w[1] = 32'h2009_0024;
        //               count   fixed flip   tog inj done
        tbl[0] = '{16'd2,  1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{16'd2,  1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{16'd2,  1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{16'h41, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{16'h40, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{16'd0,  1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{16'd0,  1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{16'd2,  1'b1, 8'h00, 1'b1, 1'b1, 1'b1};
        tbl[8] = '{16'd3,  1'b0, 8'h80, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{16'd1,  1'b0, 8'h00, 1'b1, 1'b0, 1'b1};

        resetn   = 1'b0;
        ld_start = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        fork
            monitor();
        join_none

        #1;
        check("reset_ctrl", {26'd0, in_ready, im_we, cpu_resetn, ld_busy, ld_done, ld_err}, 32'd0);
        check("reset_addr", {26'd0, im_addr}, 32'd0);
        check("reset_wdata", im_wdata, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        check("idle_cpu_released", {31'd0, cpu_resetn}, 32'd1);
        check("idle_ready", {31'd0, in_ready}, 32'd0);

        for (int i = 0; i < 10; i++) run_load(tbl[i]);

        // Reset in the middle of the second word: first word written, second partial.
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        w = 32'h2008_0013;
        exp_q.push_back('{addr: '0, data: w});
        for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], 1'b0);
        send_byte(8'h24, 1'b0);
        send_byte(8'h00, 1'b0);
        check("pre_reset_writes_pending", exp_q.size(), 32'd0);
        resetn = 1'b0;
        #1;
        check("midreset_ctrl", {26'd0, in_ready, im_we, cpu_resetn, ld_busy, ld_done, ld_err}, 32'd0);
        check("midreset_addr", {26'd0, im_addr}, 32'd0);
        check("midreset_wdata", im_wdata, 32'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        check("release_cpu_still_held", {31'd0, cpu_resetn}, 32'd0);
        @(posedge clock);
        #1;
        check("release_cpu_resetn", {31'd0, cpu_resetn}, 32'd1);
        check("release_idle", {28'd0, ld_busy, in_ready, ld_done, ld_err}, 32'd0);
        repeat (8) begin
            @(posedge clock);
            #1;
        end
        check("release_no_write", {31'd0, im_we}, 32'd0);

        // Bytes offered in IDLE are not consumed and trigger nothing.
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        check("idle_ignores_bytes", {29'd0, ld_busy, in_ready, cpu_resetn}, 32'd1);

        // A normal load still works after the reset.
        run_load(tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
